// File: rtl/vertical_strip_scanner.sv
// ============================================================================
// vertical_strip_scanner
//
// Purpose:
//   Column scanner for binary digit images. A start handshake latches a full
//   HEIGHT x LENGTH image. The scanner then walks it left to right,
//   COLS_PER_CYCLE columns per clock, to find the leftmost column that has
//   any set pixel. It then returns the HEIGHT-bit vertical strip located
//   OFFSET columns to the right of that edge.
//
// Configuration macro:
//   VSTRIP_CLAMP_EN - when defined, an out-of-range target column is clamped
//                     to LENGTH-1. When undefined, an out-of-range target
//                     yields an all-zero strip. In both cases oor_out = 1.
//
// Ports:
//   clk_in        in   1                  sole clock, rising edge
//   rst_in        in   1                  synchronous active-low reset
//   image_in      in   [HEIGHT][LENGTH]   image, [r][c], c = 0 leftmost
//   start_in      in   1                  request, accepted with ready_out
//   ready_out     out  1                  high in IDLE and DONE
//   valid_out     out  1                  one-cycle pulse, new result
//   strip_out     out  [HEIGHT]           strip_out[r] = image[r][target]
//   edge_col_out  out  [clog2(LENGTH)]    leftmost set column
//   empty_out     out  1                  image had no set pixel
//   oor_out       out  1                  edge + OFFSET >= LENGTH
// ============================================================================
module vertical_strip_scanner #(
    parameter int HEIGHT         = 200,
    parameter int LENGTH         = 200,
    parameter int OFFSET         = 30,
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic [HEIGHT-1:0][LENGTH-1:0]    image_in,
    input  logic                             start_in,
    output logic                             ready_out,
    output logic                             valid_out,
    output logic [HEIGHT-1:0]                strip_out,
    output logic [$clog2(LENGTH)-1:0]        edge_col_out,
    output logic                             empty_out,
    output logic                             oor_out
);

    localparam int CW = $clog2(LENGTH);
    localparam int P  = COLS_PER_CYCLE;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SCAN    = 2'd1;
    localparam logic [1:0] ST_EXTRACT = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // Column base of the last group; the scan ends here when nothing hits.
    localparam logic [CW-1:0] LAST_BASE = CW'(LENGTH - P);

    logic [1:0]                      state_r;
    logic [HEIGHT-1:0][LENGTH-1:0]   img_r;
    logic [CW-1:0]                   base_r;
    logic [CW-1:0]                   edge_r;
    logic                            ready_r;
    logic                            valid_r;
    logic [HEIGHT-1:0]               strip_r;
    logic [CW-1:0]                   edge_col_r;
    logic                            empty_r;
    logic                            oor_r;

    logic [LENGTH-1:0]               col_hit_s;
    logic [P-1:0]                    grp_s;
    logic                            hit_s;
    logic [CW-1:0]                   hit_idx_s;
    logic [CW:0]                     tgt_s;
    logic                            in_range_s;
    logic [CW-1:0]                   col_idx_s;
    logic [HEIGHT-1:0]               tgt_strip_s;

    // Per-column OR over all rows of the latched image.
    always_comb begin
        col_hit_s = {LENGTH{1'b0}};
        for (int c = 0; c < LENGTH; c++) begin
            for (int r = 0; r < HEIGHT; r++) begin
                col_hit_s[c] = col_hit_s[c] | img_r[r][c];
            end
        end
    end

    // Lowest hitting column inside the group currently being scanned.
    // Iterating downwards leaves the smallest index as the final winner.
    always_comb begin
        grp_s     = col_hit_s[base_r +: P];
        hit_s     = 1'b0;
        hit_idx_s = {CW{1'b0}};
        for (int k = P - 1; k >= 0; k--) begin
            if (grp_s[k]) begin
                hit_s     = 1'b1;
                hit_idx_s = CW'(k);
            end else begin
                hit_s     = hit_s;
            end
        end
    end

    // Target column computed one bit wider than a column index so it cannot
    // wrap. Out-of-range handling depends on the clamp option.
    always_comb begin
        tgt_s       = {1'b0, edge_r} + (CW+1)'(OFFSET);
        in_range_s  = (tgt_s < (CW+1)'(LENGTH));
`ifdef VSTRIP_CLAMP_EN
        if (in_range_s) begin
            col_idx_s = tgt_s[CW-1:0];
        end else begin
            col_idx_s = CW'(LENGTH - 1);
        end
        for (int r = 0; r < HEIGHT; r++) begin
            tgt_strip_s[r] = img_r[r][col_idx_s];
        end
`else
        if (in_range_s) begin
            col_idx_s = tgt_s[CW-1:0];
        end else begin
            col_idx_s = {CW{1'b0}};
        end
        for (int r = 0; r < HEIGHT; r++) begin
            tgt_strip_s[r] = in_range_s ? img_r[r][col_idx_s] : 1'b0;
        end
`endif
    end

    // Control FSM, image buffer and registered result outputs.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_r    <= ST_IDLE;
            img_r      <= '0;
            base_r     <= {CW{1'b0}};
            edge_r     <= {CW{1'b0}};
            ready_r    <= 1'b1;
            valid_r    <= 1'b0;
            strip_r    <= {HEIGHT{1'b0}};
            edge_col_r <= {CW{1'b0}};
            empty_r    <= 1'b0;
            oor_r      <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start_in) begin
                        img_r   <= image_in;
                        base_r  <= {CW{1'b0}};
                        empty_r <= 1'b0;
                        oor_r   <= 1'b0;
                        ready_r <= 1'b0;
                        state_r <= ST_SCAN;
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (hit_s) begin
                        edge_r  <= base_r + hit_idx_s;
                        state_r <= ST_EXTRACT;
                    end else if (base_r == LAST_BASE) begin
                        strip_r    <= {HEIGHT{1'b0}};
                        edge_col_r <= {CW{1'b0}};
                        empty_r    <= 1'b1;
                        oor_r      <= 1'b0;
                        valid_r    <= 1'b1;
                        ready_r    <= 1'b1;
                        state_r    <= ST_DONE;
                    end else begin
                        base_r <= base_r + CW'(P);
                    end
                end
                ST_EXTRACT: begin
                    strip_r    <= tgt_strip_s;
                    edge_col_r <= edge_r;
                    empty_r    <= 1'b0;
                    oor_r      <= ~in_range_s;
                    valid_r    <= 1'b1;
                    ready_r    <= 1'b1;
                    state_r    <= ST_DONE;
                end
                default: begin
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready_out    = ready_r;
    assign valid_out    = valid_r;
    assign strip_out    = strip_r;
    assign edge_col_out = edge_col_r;
    assign empty_out    = empty_r;
    assign oor_out      = oor_r;

endmodule

// File: tb/tb_vertical_strip_scanner.sv
// ============================================================================
// tb_vertical_strip_scanner
//
// Self-checking bench for vertical_strip_scanner. The DUT is configured with
// HEIGHT=8, LENGTH=16, OFFSET=3 and COLS_PER_CYCLE=4. Expected results come
// from a constant vector table. They are pushed to a scoreboard queue when a
// start is driven, and popped when valid_out pulses.
// ============================================================================
module tb_vertical_strip_scanner;

    localparam int H   = 8;
    localparam int L   = 16;
    localparam int OFF = 3;
    localparam int P   = 4;
    localparam int CW  = 4;
    localparam int NV  = 7;

    typedef logic [H-1:0][L-1:0] img_t;

    typedef struct {
        int          lat;
        logic [H-1:0] strip;
        logic [CW-1:0] edge_col;
        logic        empty;
        logic        oor;
    } exp_t;

    typedef struct {
        img_t img;
        exp_t e;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst_in;
    img_t               image_in;
    logic               start_in;
    logic               ready_out;
    logic               valid_out;
    logic [H-1:0]       strip_out;
    logic [CW-1:0]      edge_col_out;
    logic               empty_out;
    logic               oor_out;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    vec_t vecs[NV];

    always #5 clk = ~clk;

    vertical_strip_scanner #(
        .HEIGHT(H), .LENGTH(L), .OFFSET(OFF), .COLS_PER_CYCLE(P)
    ) dut (
        .clk_in(clk), .rst_in(rst_in), .image_in(image_in), .start_in(start_in),
        .ready_out(ready_out), .valid_out(valid_out), .strip_out(strip_out),
        .edge_col_out(edge_col_out), .empty_out(empty_out), .oor_out(oor_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic img_t put_col(input img_t img, input int c, input logic [H-1:0] v);
        img_t t;
        t = img;
        for (int r = 0; r < H; r++) t[r][c] = v[r];
        return t;
    endfunction

    function automatic img_t put_px(input img_t img, input int r, input int c);
        img_t t;
        t = img;
        t[r][c] = 1'b1;
        return t;
    endfunction

    task automatic set_vec(input int i, input img_t img, input int lat, input logic [H-1:0] strip,
                           input logic [CW-1:0] ec, input logic emp, input logic oor);
        vecs[i].img        = img;
        vecs[i].e.lat      = lat;
        vecs[i].e.strip    = strip;
        vecs[i].e.edge_col = ec;
        vecs[i].e.empty    = emp;
        vecs[i].e.oor      = oor;
    endtask

    // Wait (bounded) for ready, then present one start. Returns #1 after the accept edge.
    task automatic drive(input img_t img, input exp_t e, input bit push);
        int w;
        w = 0;
        while (!ready_out && w < 50) begin
            @(posedge clk); #1; w++;
        end
        chk("ready_before_start", {31'd0, ready_out}, 32'd1);
        image_in = img;
        start_in = 1'b1;
        if (push) sb_q.push_back(e);
        @(posedge clk); #1;
        start_in = 1'b0;
        image_in = '0;
    endtask

    // Wait (bounded) for valid_out, then compare against the scoreboard head.
    task automatic collect(input int start_cnt);
        int   cnt;
        exp_t e;
        cnt = start_cnt;
        while (!valid_out && cnt < 40) begin
            @(posedge clk); #1; cnt++;
        end
        chk("valid_seen", {31'd0, valid_out}, 32'd1);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got result with no expectation queued");
        end else begin
            e = sb_q.pop_front();
            chk("latency", cnt, e.lat);
            chk("strip", {24'd0, strip_out}, {24'd0, e.strip});
            chk("edge_col", {28'd0, edge_col_out}, {28'd0, e.edge_col});
            chk("empty", {31'd0, empty_out}, {31'd0, e.empty});
            chk("oor", {31'd0, oor_out}, {31'd0, e.oor});
            chk("ready_at_valid", {31'd0, ready_out}, 32'd1);
        end
    endtask

    initial begin
        img_t t;
        exp_t dummy;
        logic [H-1:0] oor_strip_14;
        logic [H-1:0] oor_strip_13;
`ifdef VSTRIP_CLAMP_EN
        oor_strip_14 = 8'h80;
        oor_strip_13 = 8'hFF;
`else
        oor_strip_14 = 8'h00;
        oor_strip_13 = 8'h00;
`endif
        // Vector table: {image, latency, strip, edge, empty, oor}
        t = put_col(put_px('0, 2, 5), 8, 8'hA5);   set_vec(0, t, 3, 8'hA5, 4'd5,  1'b0, 1'b0);
        t = put_col(put_px('0, 0, 0), 3, 8'h0F);   set_vec(1, t, 2, 8'h0F, 4'd0,  1'b0, 1'b0);
        t = '0;                                    set_vec(2, t, 4, 8'h00, 4'd0,  1'b1, 1'b0);
        t = put_col(put_px('0, 7, 14), 15, 8'h80); set_vec(3, t, 5, oor_strip_14, 4'd14, 1'b0, 1'b1);
        t = put_col(put_px('0, 1, 12), 15, 8'h3C); set_vec(4, t, 5, 8'h3C, 4'd12, 1'b0, 1'b0);
        t = put_col(put_px('0, 4, 13), 15, 8'hFF); set_vec(5, t, 5, oor_strip_13, 4'd13, 1'b0, 1'b1);
        t = put_col(put_px('0, 6, 7), 10, 8'h5A);  set_vec(6, t, 3, 8'h5A, 4'd7,  1'b0, 1'b0);
        dummy = vecs[2].e;

        // Reset held two cycles with start asserted: no accept, reset outputs.
        rst_in   = 1'b0;
        start_in = 1'b1;
        image_in = vecs[0].img;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_ready", {31'd0, ready_out}, 32'd1);
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_strip", {24'd0, strip_out}, 32'd0);
        chk("rst_edge", {28'd0, edge_col_out}, 32'd0);
        chk("rst_empty", {31'd0, empty_out}, 32'd0);
        chk("rst_oor", {31'd0, oor_out}, 32'd0);
        start_in = 1'b0;
        image_in = '0;
        rst_in   = 1'b1;
        @(posedge clk); #1;
        chk("idle_no_accept", {31'd0, ready_out}, 32'd1);

        // Table-driven pass, one start per vector, with gap cycle checks.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].img, vecs[i].e, 1'b1);
            collect(0);
            @(posedge clk); #1;
            chk("valid_pulse_drop", {31'd0, valid_out}, 32'd0);
            chk("done_hold_edge", {28'd0, edge_col_out}, {28'd0, vecs[i].e.edge_col});
            chk("done_hold_strip", {24'd0, strip_out}, {24'd0, vecs[i].e.strip});
        end

        // start pulsed during SCAN with a different image is ignored.
        drive(vecs[2].img, vecs[2].e, 1'b1);
        chk("scan_not_ready", {31'd0, ready_out}, 32'd0);
        image_in = vecs[1].img;
        start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        image_in = '0;
        collect(1);

        // Reset mid-SCAN aborts; outputs return to reset values next cycle.
        @(posedge clk); #1;
        drive(vecs[3].img, dummy, 1'b0);
        rst_in = 1'b0;
        @(posedge clk); #1;
        rst_in = 1'b1;
        chk("abort_ready", {31'd0, ready_out}, 32'd1);
        chk("abort_valid", {31'd0, valid_out}, 32'd0);
        chk("abort_strip", {24'd0, strip_out}, 32'd0);
        chk("abort_edge", {28'd0, edge_col_out}, 32'd0);
        chk("abort_empty", {31'd0, empty_out}, 32'd0);
        chk("abort_oor", {31'd0, oor_out}, 32'd0);

        // Back-to-back: each new start lands in the first DONE cycle.
        drive(vecs[5].img, vecs[5].e, 1'b1);
        collect(0);
        drive(vecs[1].img, vecs[1].e, 1'b1);
        chk("b2b_empty_cleared", {31'd0, empty_out}, 32'd0);
        collect(0);
        drive(vecs[2].img, vecs[2].e, 1'b1);
        collect(0);
        drive(vecs[0].img, vecs[0].e, 1'b1);
        collect(0);

        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
